gac_dmux_1t8_32_buf: RTL and testbench
======================================

Name: gac_dmux_1t8_32_buf

Overview:
- Registered 1-to-8 demultiplexer with valid/ready handshake: the distributing counterpart of the 8-to-1 32-bit select mux.
- Routes one 32-bit word per cycle from a single producer to one of eight consumer lanes, or broadcasts it to all lanes.
- Each lane has a one-entry holding register.
- Sits between the issue stage and per-unit operand latches in the superscalar datapath.

Parameters:
- WIDTH, 32, data width per lane.
- LANES, 8, number of output lanes (fixed at 8 for this revision).
- SEL_W, 3, select width, log2(LANES).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  block can accept the word this cycle.
- in_data  input  WIDTH  word to distribute.
- in_sel  input  SEL_W  destination lane; ignored when in_bcast=1.
- in_bcast  input  1  write word to all LANES lanes.
- out_valid  output  LANES  per-lane holding register full.
- out_ready  input  LANES  per-lane consumer accepts.
- out_data  output  LANES*WIDTH  lane i occupies bits [WIDTH*i+WIDTH-1 : WIDTH*i].
- occupancy  output  4  count of lanes with out_valid set, 0..8.

Behaviour:
- Reset (reset_n=0, asynchronous assert, synchronous-to-clk deassert by the system):
  - out_valid=0, out_data=0, occupancy=0.
  - Held words are discarded. Reset mid-transfer loses no more than held data; no partial state survives.
  - in_ready is 0 while reset_n=0.
- Lane free condition: free[i] = !out_valid[i] || out_ready[i]. A full lane being drained this cycle counts as free (zero-bubble pass-through).
- Ready logic:
  - Unicast: in_ready = free[in_sel].
  - Broadcast: in_ready = AND of free[0..7].
  - in_ready is combinational on out_ready, in_sel and in_bcast. It must not depend on in_valid.
- Accept = in_valid && in_ready.
  - Unicast accept: lane in_sel loads in_data; out_valid[in_sel]=1 next edge.
  - Broadcast accept: all lanes load in_data; all out_valid=1 next edge.
- Latency: 1 cycle from accept to out_valid/out_data visible. Throughput: 1 word per cycle.
- Per-lane next state, in priority order:
  - load (accept targeting lane): out_valid=1, out_data=in_data. This covers simultaneous drain and load, so the new word replaces the drained one with no gap.
  - else drain (out_valid && out_ready): out_valid=0, out_data holds its last value.
  - else: hold.
- out_data of an invalid lane is don't-care for consumers but must be stable. It is not cleared on drain.
- Holding rule: while out_valid[i]=1 and out_ready[i]=0, out_data lane i is stable.
- Producer rule: the producer may change in_data, in_sel and in_bcast while in_valid=0 or after accept. The block makes no assumption of stability before accept.
- occupancy is registered and equals the popcount of the next out_valid vector, updated on the same edge as out_valid.
- in_sel out of range cannot occur (SEL_W=3, LANES=8).
- Broadcast while any lane is full and not draining: in_ready=0, no lane is written. Broadcast is all-or-nothing.
- No internal state machine beyond the per-lane valid bits: each lane is a 2-state (EMPTY/FULL) machine with the transitions above.

Decomposition:
- Shared package: WIDTH, LANES, SEL_W constants; lane slice index function (base = WIDTH*i).
- One sub-module: gac_dmux_lane_reg. It contains one holding register plus valid flag, with inputs load, data, drain_ready, and outputs valid, data, free.
- The top generates 8 instances plus the select decode, ready mux/AND-reduce and popcount.

Test Plan:
- Reset: assert reset_n=0 mid-stream with lanes 2 and 5 full -> out_valid=8'h00, occupancy=0, out_data=0 immediately (asynchronous); in_ready=0 during reset.
- Unicast fill: in_sel=3, in_data=32'hDEADBEEF, out_ready=0 -> next cycle out_valid=8'b0000_1000, lane 3 data DEADBEEF, occupancy=1. A second word to sel=3 sees in_ready=0 and is not taken.
- Pass-through: lane 3 full, out_ready[3]=1, in_sel=3, in_data=32'h12345678 -> in_ready=1; next cycle lane 3 data 12345678, out_valid[3] remains 1, occupancy unchanged.
- Broadcast blocked/released: lane 6 full with out_ready[6]=0, in_bcast=1 -> in_ready=0, no lane changes. Raise out_ready[6] -> accept; next cycle out_valid=8'hFF, every lane = in_data, occupancy=8.
- Streaming round-robin: in_sel 0..7 back-to-back with all out_ready=1 -> one accept per cycle, each lane pulses valid for 1 cycle with matching data, occupancy stays 1 after the first edge.

Source files
------------

// File: rtl/gac_dmux_1t8_32_buf_pkg.sv
// Shared constants, lane state encoding and lane slicing helper for the
// 1-to-8 registered demultiplexer.
package gac_dmux_1t8_32_buf_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned LANES = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_t;

    // Lane i occupies out_data[lane_base(i) +: WIDTH]
    function automatic int unsigned lane_base(input int unsigned i);
        return WIDTH * i;
    endfunction

endpackage

// File: rtl/gac_dmux_lane_reg.sv
// One-entry holding register with valid flag; a draining lane counts as free
// so a new word can replace it on the same edge.
module gac_dmux_lane_reg #(
    parameter int unsigned WIDTH = gac_dmux_1t8_32_buf_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] wdata,
    input  logic             drain_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             free
);
    import gac_dmux_1t8_32_buf_pkg::*;

    lane_state_t      state_q;
    lane_state_t      state_d;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= LANE_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                data_q <= wdata;
            end
        end
    end

    // Load wins over drain; drained data is kept, only the flag drops
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = LANE_FULL;
        end else if (state_q == LANE_FULL && drain_ready) begin
            state_d = LANE_EMPTY;
        end
    end

    assign valid = (state_q == LANE_FULL);
    assign data  = data_q;
    assign free  = !valid || drain_ready;

endmodule

// File: rtl/gac_dmux_1t8_32_buf.sv
// Registered 1-to-8 demultiplexer with valid/ready handshake: unicast to one
// lane or all-or-nothing broadcast, plus registered lane occupancy count.
module gac_dmux_1t8_32_buf #(
    parameter int unsigned WIDTH = gac_dmux_1t8_32_buf_pkg::WIDTH,
    parameter int unsigned LANES = gac_dmux_1t8_32_buf_pkg::LANES,
    parameter int unsigned SEL_W = gac_dmux_1t8_32_buf_pkg::SEL_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_bcast,
    output logic [LANES-1:0]       out_valid,
    input  logic [LANES-1:0]       out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [3:0]             occupancy
);
    import gac_dmux_1t8_32_buf_pkg::*;

    logic [LANES-1:0] free;
    logic [LANES-1:0] load;
    logic [LANES-1:0] valid_next;
    logic [3:0]       occ_next;
    logic             accept;

    assign in_ready = reset_n && (in_bcast ? (&free) : free[in_sel]);
    assign accept   = in_valid && in_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign load[i] = accept && (in_bcast || (in_sel == SEL_W'(i)));

        gac_dmux_lane_reg #(
            .WIDTH(WIDTH)
        ) u_lane (
            .clk        (clk),
            .reset_n    (reset_n),
            .load       (load[i]),
            .wdata      (in_data),
            .drain_ready(out_ready[i]),
            .valid      (out_valid[i]),
            .data       (out_data[lane_base(i) +: WIDTH]),
            .free       (free[i])
        );
    end

    // Occupancy tracks the valid vector the lanes will hold after this edge
    always_comb begin
        valid_next = load | (out_valid & ~out_ready);
        occ_next   = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            occ_next = occ_next + {3'b000, valid_next[i]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_next;
        end
    end

endmodule

// File: tb/tb_gac_dmux_1t8_32_buf.sv
// Self-checking bench: directed scenarios then random traffic against a
// per-lane array model of the demultiplexer.
module tb_gac_dmux_1t8_32_buf;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic [2:0]   in_sel;
    logic         in_bcast;
    logic [7:0]   out_valid;
    logic [7:0]   out_ready;
    logic [255:0] out_data;
    logic [3:0]   occupancy;

    int checks = 0;
    int errors = 0;

    logic        mv [8];
    logic [31:0] md [8];

    gac_dmux_1t8_32_buf dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_bcast (in_bcast),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_valid();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = mv[i];
        return v;
    endfunction

    function automatic logic [255:0] m_data();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[32*i +: 32] = md[i];
        return d;
    endfunction

    function automatic logic [3:0] m_occ();
        int n = 0;
        for (int i = 0; i < 8; i++) if (mv[i]) n++;
        return 4'(n);
    endfunction

    function automatic logic m_ready();
        logic all_free = 1'b1;
        for (int i = 0; i < 8; i++) if (mv[i] && !out_ready[i]) all_free = 1'b0;
        if (in_bcast) return all_free;
        return !mv[in_sel] || out_ready[in_sel];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) begin
            mv[i] = 1'b0;
            md[i] = '0;
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] sel, input logic bc,
                         input logic [31:0] d, input logic [7:0] ordy);
        in_valid  = v;
        in_sel    = sel;
        in_bcast  = bc;
        in_data   = d;
        out_ready = ordy;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_valid"}, 256'(out_valid), 256'(m_valid()));
        chk({tag, "_data"}, out_data, m_data());
        chk({tag, "_occ"}, 256'(occupancy), 256'(m_occ()));
    endtask

    // One clock of traffic: check ready mid-cycle, then update model and outputs
    task automatic step(input string tag);
        logic acc;
        @(negedge clk);
        chk({tag, "_ready"}, 256'(in_ready), 256'(m_ready()));
        acc = in_valid && m_ready();
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            if (acc && (in_bcast || int'(in_sel) == i)) begin
                mv[i] = 1'b1;
                md[i] = in_data;
            end else if (mv[i] && out_ready[i]) begin
                mv[i] = 1'b0;
            end
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        m_reset();
        reset_n = 1'b0;
        drive(1'b1, 3'd0, 1'b0, 32'hA5A5_A5A5, 8'h00);
        #2;
        chk("rst_ready", 256'(in_ready), 256'(1'b0));
        check_outputs("rst");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Unicast fill and blocked second write
        drive(1'b1, 3'd3, 1'b0, 32'hDEADBEEF, 8'h00);
        step("uni_fill");
        drive(1'b1, 3'd3, 1'b0, 32'h0BAD_0BAD, 8'h00);
        step("uni_block");

        // Pass-through on a draining lane
        drive(1'b1, 3'd3, 1'b0, 32'h12345678, 8'h08);
        step("pass");

        // Broadcast blocked by lanes 3 and 6, then released
        drive(1'b1, 3'd6, 1'b0, 32'h6666_0006, 8'h00);
        step("fill6");
        drive(1'b1, 3'd1, 1'b1, 32'hCAFE_F00D, 8'h00);
        step("bc_block");
        drive(1'b1, 3'd1, 1'b1, 32'hCAFE_F00D, 8'h08);
        step("bc_block3");
        drive(1'b1, 3'd1, 1'b1, 32'hCAFE_F00D, 8'h48);
        step("bc_go");
        drive(1'b0, 3'd0, 1'b0, 32'h0, 8'hFF);
        step("drain_all");

        // Round-robin streaming with all consumers ready
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 1'b0, 32'h1000_0000 + 32'(i), 8'hFF);
            step("rr");
        end
        drive(1'b0, 3'd0, 1'b0, 32'h0, 8'hFF);
        step("rr_end");

        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 7) == 0), 32'($urandom), 8'($urandom));
            step("rand");
        end

        // Asynchronous reset with lanes 2 and 5 full
        drive(1'b0, 3'd0, 1'b0, 32'h0, 8'hFF);
        step("pre_rst");
        drive(1'b1, 3'd2, 1'b0, 32'h2222_2222, 8'h00);
        step("fill2");
        drive(1'b1, 3'd5, 1'b0, 32'h5555_5555, 8'h00);
        step("fill5");
        drive(1'b1, 3'd7, 1'b0, 32'h7777_7777, 8'h00);
        #2;
        reset_n = 1'b0;
        m_reset();
        #1;
        chk("mid_rst_ready", 256'(in_ready), 256'(1'b0));
        check_outputs("mid_rst");
        @(posedge clk);
        #1;
        check_outputs("mid_rst_hold");
        reset_n = 1'b1;
        drive(1'b1, 3'd4, 1'b0, 32'h4444_4444, 8'h00);
        step("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
